// File: rtl/decode_stage_pkg.sv
// ============================================================================
// Module   : decode_stage_pkg
// Brief    : Shared control encodings, opcodes and decode helpers.
// Revision : 1.0
// ============================================================================
`default_nettype none

package decode_stage_pkg;

    // RV32I ALU codes keep their values; the M codes extend the range.
    typedef enum logic [4:0] {
        ALU_NONE   = 5'd0,
        ALU_ADD    = 5'd1,
        ALU_SUB    = 5'd2,
        ALU_SLL    = 5'd3,
        ALU_SLT    = 5'd4,
        ALU_SLTU   = 5'd5,
        ALU_XOR    = 5'd6,
        ALU_SRL    = 5'd7,
        ALU_SRA    = 5'd8,
        ALU_OR     = 5'd9,
        ALU_AND    = 5'd10,
        ALU_MUL    = 5'd11,
        ALU_MULH   = 5'd12,
        ALU_MULHSU = 5'd13,
        ALU_MULHU  = 5'd14,
        ALU_DIV    = 5'd15,
        ALU_DIVU   = 5'd16,
        ALU_REM    = 5'd17,
        ALU_REMU   = 5'd18
    } alu_op_e;

    typedef enum logic [2:0] {
        JUMP_NONE = 3'd0,
        JUMP_JAL  = 3'd1,
        JUMP_JALR = 3'd2,
        JUMP_IF_0 = 3'd3,
        JUMP_IF_1 = 3'd4
    } jump_e;

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_ALU  = 3'd1,
        SRC_MEM  = 3'd2,
        SRC_PC4  = 3'd3,
        SRC_IMM  = 3'd4
    } regsrc_e;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } mem_op_e;

    typedef enum logic [2:0] {
        RD_NONE = 3'd0,
        RD_LB   = 3'd1,
        RD_LH   = 3'd2,
        RD_LW   = 3'd3,
        RD_LBU  = 3'd4,
        RD_LHU  = 3'd5
    } mem_read_e;

    localparam logic [3:0] MASK_NONE = 4'b0000;
    localparam logic [3:0] MASK_B    = 4'b0001;
    localparam logic [3:0] MASK_H    = 4'b0011;
    localparam logic [3:0] MASK_W    = 4'b1111;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef struct packed {
        alu_op_e    alu_op;
        logic       alu1_pc;
        logic       alu2_imm;
        jump_e      jump_type;
        regsrc_e    regfile_src;
        mem_op_e    mem_op;
        mem_read_e  mem_read_type;
        logic [3:0] mem_write_mask;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic alu_op_e muldiv_from_funct3(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_MUL;
            3'b001:  return ALU_MULH;
            3'b010:  return ALU_MULHSU;
            3'b011:  return ALU_MULHU;
            3'b100:  return ALU_DIV;
            3'b101:  return ALU_DIVU;
            3'b110:  return ALU_REM;
            default: return ALU_REMU;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/decode_stage_instr_decoder.sv
// ============================================================================
// Module   : instr_decoder
// Brief    : Pure combinational RV32I(+M) decode into a control bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_decoder #(
    parameter int XLEN = 32,
    parameter int EN_M = 0
) (
    input  logic [31:0]                    instr,
    output decode_stage_pkg::ctrl_t        ctrl,
    output logic [4:0]                     rd,
    output logic [4:0]                     rs1,
    output logic [4:0]                     rs2,
    output logic [XLEN-1:0]                imm,
    output logic                           illegal
);
    import decode_stage_pkg::*;

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_imm32;
    logic        w_bad;

    assign w_opcode = instr[6:0];
    assign w_f3     = instr[14:12];
    assign w_f7     = instr[31:25];

    assign w_imm_i = {{20{instr[31]}}, instr[31:20]};
    assign w_imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign w_imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign w_imm_u = {instr[31:12], 12'b0};
    assign w_imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        ctrl    = CTRL_NONE;
        rd      = 5'd0;
        rs1     = 5'd0;
        rs2     = 5'd0;
        w_imm32 = 32'd0;
        w_bad   = 1'b0;

        case (w_opcode)
            OP_LUI: begin
                rd               = instr[11:7];
                w_imm32          = w_imm_u;
                ctrl.regfile_src = SRC_IMM;
            end
            OP_AUIPC: begin
                rd               = instr[11:7];
                w_imm32          = w_imm_u;
                ctrl.alu_op      = ALU_ADD;
                ctrl.alu1_pc     = 1'b1;
                ctrl.alu2_imm    = 1'b1;
                ctrl.regfile_src = SRC_ALU;
            end
            OP_JAL: begin
                rd               = instr[11:7];
                w_imm32          = w_imm_j;
                ctrl.alu_op      = ALU_ADD;
                ctrl.alu1_pc     = 1'b1;
                ctrl.alu2_imm    = 1'b1;
                ctrl.jump_type   = JUMP_JAL;
                ctrl.regfile_src = SRC_PC4;
            end
            OP_JALR: begin
                rd               = instr[11:7];
                rs1              = instr[19:15];
                w_imm32          = w_imm_i;
                ctrl.alu_op      = ALU_ADD;
                ctrl.alu2_imm    = 1'b1;
                ctrl.jump_type   = JUMP_JALR;
                ctrl.regfile_src = SRC_PC4;
                w_bad            = (w_f3 != 3'b000);
            end
            OP_BRANCH: begin
                rs1     = instr[19:15];
                rs2     = instr[24:20];
                w_imm32 = w_imm_b;
                // Equality compares via XOR (zero means equal); ordering via SLT/SLTU.
                case (w_f3)
                    3'b000:  begin ctrl.alu_op = ALU_XOR;  ctrl.jump_type = JUMP_IF_0; end
                    3'b001:  begin ctrl.alu_op = ALU_XOR;  ctrl.jump_type = JUMP_IF_1; end
                    3'b100:  begin ctrl.alu_op = ALU_SLT;  ctrl.jump_type = JUMP_IF_1; end
                    3'b101:  begin ctrl.alu_op = ALU_SLT;  ctrl.jump_type = JUMP_IF_0; end
                    3'b110:  begin ctrl.alu_op = ALU_SLTU; ctrl.jump_type = JUMP_IF_1; end
                    3'b111:  begin ctrl.alu_op = ALU_SLTU; ctrl.jump_type = JUMP_IF_0; end
                    default: w_bad = 1'b1;
                endcase
            end
            OP_LOAD: begin
                rd               = instr[11:7];
                rs1              = instr[19:15];
                w_imm32          = w_imm_i;
                ctrl.alu_op      = ALU_ADD;
                ctrl.alu2_imm    = 1'b1;
                ctrl.regfile_src = SRC_MEM;
                ctrl.mem_op      = MEM_READ;
                case (w_f3)
                    3'b000:  ctrl.mem_read_type = RD_LB;
                    3'b001:  ctrl.mem_read_type = RD_LH;
                    3'b010:  ctrl.mem_read_type = RD_LW;
                    3'b100:  ctrl.mem_read_type = RD_LBU;
                    3'b101:  ctrl.mem_read_type = RD_LHU;
                    default: w_bad = 1'b1;
                endcase
            end
            OP_STORE: begin
                rs1           = instr[19:15];
                rs2           = instr[24:20];
                w_imm32       = w_imm_s;
                ctrl.alu_op   = ALU_ADD;
                ctrl.alu2_imm = 1'b1;
                ctrl.mem_op   = MEM_WRITE;
                case (w_f3)
                    3'b000:  ctrl.mem_write_mask = MASK_B;
                    3'b001:  ctrl.mem_write_mask = MASK_H;
                    3'b010:  ctrl.mem_write_mask = MASK_W;
                    default: w_bad = 1'b1;
                endcase
            end
            OP_IMM: begin
                rd               = instr[11:7];
                rs1              = instr[19:15];
                w_imm32          = w_imm_i;
                ctrl.alu2_imm    = 1'b1;
                ctrl.regfile_src = SRC_ALU;
                ctrl.alu_op      = alu_from_funct3(w_f3, (w_f3 == 3'b101) && (w_f7 == F7_ALT));
                if (w_f3 == 3'b001)
                    w_bad = (w_f7 != F7_BASE);
                else if (w_f3 == 3'b101)
                    w_bad = (w_f7 != F7_BASE) && (w_f7 != F7_ALT);
            end
            OP_OP: begin
                rd               = instr[11:7];
                rs1              = instr[19:15];
                rs2              = instr[24:20];
                ctrl.regfile_src = SRC_ALU;
                if (w_f7 == F7_BASE)
                    ctrl.alu_op = alu_from_funct3(w_f3, 1'b0);
                else if ((w_f7 == F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)))
                    ctrl.alu_op = alu_from_funct3(w_f3, 1'b1);
                else if ((w_f7 == F7_MULDIV) && (EN_M != 0))
                    ctrl.alu_op = muldiv_from_funct3(w_f3);
                else
                    w_bad = 1'b1;
            end
            default: w_bad = 1'b1;
        endcase

        if (instr[1:0] != 2'b11)
            w_bad = 1'b1;

        // Illegal words still flow down the pipe, but carry no side effects.
        if (w_bad) begin
            ctrl    = CTRL_NONE;
            rd      = 5'd0;
            rs1     = 5'd0;
            rs2     = 5'd0;
            w_imm32 = 32'd0;
        end
    end

    assign imm     = XLEN'($signed(w_imm32));
    assign illegal = w_bad;

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ============================================================================
// Module   : decode_stage
// Brief    : Valid/ready decode pipeline stage with a single output register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module decode_stage #(
    parameter int XLEN = 32,
    parameter int EN_M = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_alu_op,
    output logic            out_alu1_pc,
    output logic            out_alu2_imm,
    output logic [2:0]      out_jump_type,
    output logic [2:0]      out_regfile_src,
    output logic [1:0]      out_mem_op,
    output logic [2:0]      out_mem_read_type,
    output logic [3:0]      out_mem_write_mask,
    output logic            out_illegal
);
    import decode_stage_pkg::*;

    ctrl_t           w_ctrl;
    logic [4:0]      w_rd, w_rs1, w_rs2;
    logic [XLEN-1:0] w_imm;
    logic            w_illegal;
    logic            w_accept;

    instr_decoder #(
        .XLEN (XLEN),
        .EN_M (EN_M)
    ) u_instr_decoder (
        .instr   (in_instr),
        .ctrl    (w_ctrl),
        .rd      (w_rd),
        .rs1     (w_rs1),
        .rs2     (w_rs2),
        .imm     (w_imm),
        .illegal (w_illegal)
    );

    assign in_ready = !out_valid || out_ready;
    assign w_accept = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid          <= 1'b0;
            out_pc             <= '0;
            out_rd             <= 5'd0;
            out_rs1            <= 5'd0;
            out_rs2            <= 5'd0;
            out_imm            <= '0;
            out_alu_op         <= ALU_NONE;
            out_alu1_pc        <= 1'b0;
            out_alu2_imm       <= 1'b0;
            out_jump_type      <= JUMP_NONE;
            out_regfile_src    <= SRC_NONE;
            out_mem_op         <= MEM_NONE;
            out_mem_read_type  <= RD_NONE;
            out_mem_write_mask <= MASK_NONE;
            out_illegal        <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (w_accept) begin
            out_valid          <= 1'b1;
            out_pc             <= in_pc;
            out_rd             <= w_rd;
            out_rs1            <= w_rs1;
            out_rs2            <= w_rs2;
            out_imm            <= w_imm;
            out_alu_op         <= w_ctrl.alu_op;
            out_alu1_pc        <= w_ctrl.alu1_pc;
            out_alu2_imm       <= w_ctrl.alu2_imm;
            out_jump_type      <= w_ctrl.jump_type;
            out_regfile_src    <= w_ctrl.regfile_src;
            out_mem_op         <= w_ctrl.mem_op;
            out_mem_read_type  <= w_ctrl.mem_read_type;
            out_mem_write_mask <= w_ctrl.mem_write_mask;
            out_illegal        <= w_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
// Module   : tb_decode_stage
// Brief    : Directed scoreboard bench; EN_M=1 and EN_M=0 instances side by side.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_decode_stage;
    localparam int XLEN = 32;

    localparam logic [4:0] A_NONE = 5'd0, A_ADD = 5'd1, A_SUB = 5'd2, A_SLT = 5'd4,
                           A_XOR = 5'd6, A_SRA = 5'd8, A_MUL = 5'd11, A_DIVU = 5'd16;
    localparam logic [2:0] J_NONE = 3'd0, J_JAL = 3'd1, J_JALR = 3'd2, J_IF0 = 3'd3, J_IF1 = 3'd4;
    localparam logic [2:0] S_NONE = 3'd0, S_ALU = 3'd1, S_MEM = 3'd2, S_PC4 = 3'd3, S_IMM = 3'd4;
    localparam logic [1:0] M_NONE = 2'd0, M_RD = 2'd1, M_WR = 2'd2;
    localparam logic [2:0] R_NONE = 3'd0, R_LBU = 3'd4;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [4:0]  alu;
        logic        a1, a2;
        logic [2:0]  jt, src;
        logic [1:0]  mop;
        logic [2:0]  rt;
        logic [3:0]  mask;
        logic        ill, illn;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, in_valid, flush, out_ready;
    logic [31:0] in_instr, in_pc;

    logic in_ready, out_valid, out_alu1_pc, out_alu2_imm, out_illegal;
    logic [31:0] out_pc, out_imm;
    logic [4:0]  out_rd, out_rs1, out_rs2, out_alu_op;
    logic [2:0]  out_jump_type, out_regfile_src, out_mem_read_type;
    logic [1:0]  out_mem_op;
    logic [3:0]  out_mem_write_mask;

    logic n_in_ready, n_out_valid, n_alu1_pc, n_alu2_imm, n_illegal;
    logic [31:0] n_pc, n_imm;
    logic [4:0]  n_rd, n_rs1, n_rs2, n_alu_op;
    logic [2:0]  n_jump_type, n_regfile_src, n_mem_read_type;
    logic [1:0]  n_mem_op;
    logic [3:0]  n_mem_write_mask;

    decode_stage #(.XLEN(XLEN), .EN_M(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
        .out_alu_op(out_alu_op), .out_alu1_pc(out_alu1_pc), .out_alu2_imm(out_alu2_imm),
        .out_jump_type(out_jump_type), .out_regfile_src(out_regfile_src),
        .out_mem_op(out_mem_op), .out_mem_read_type(out_mem_read_type),
        .out_mem_write_mask(out_mem_write_mask), .out_illegal(out_illegal)
    );

    decode_stage #(.XLEN(XLEN), .EN_M(0)) dut_nom (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_pc(n_pc),
        .out_rd(n_rd), .out_rs1(n_rs1), .out_rs2(n_rs2), .out_imm(n_imm),
        .out_alu_op(n_alu_op), .out_alu1_pc(n_alu1_pc), .out_alu2_imm(n_alu2_imm),
        .out_jump_type(n_jump_type), .out_regfile_src(n_regfile_src),
        .out_mem_op(n_mem_op), .out_mem_read_type(n_mem_read_type),
        .out_mem_write_mask(n_mem_write_mask), .out_illegal(n_illegal)
    );

    int   compared   = 0;
    int   mismatched = 0;
    bit   m_valid    = 1'b0;
    exp_t q[$];
    exp_t nxt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] rd, rs1, rs2,
                                input logic [31:0] imm, input logic [4:0] alu,
                                input logic a1, a2, input logic [2:0] jt, src,
                                input logic [1:0] mop, input logic [2:0] rt,
                                input logic [3:0] mask, input logic ill, illn);
        exp_t e;
        e.pc = pc; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.alu = alu;
        e.a1 = a1; e.a2 = a2; e.jt = jt; e.src = src; e.mop = mop; e.rt = rt;
        e.mask = mask; e.ill = ill; e.illn = illn;
        return e;
    endfunction

    function automatic exp_t mk_ill(input logic [31:0] pc);
        return mk(pc, 5'd0, 5'd0, 5'd0, 32'd0, A_NONE, 1'b0, 1'b0, J_NONE, S_NONE,
                  M_NONE, R_NONE, 4'd0, 1'b1, 1'b0);
    endfunction

    task automatic chk_bundle(input exp_t e);
        chk("pc",        out_pc, e.pc);
        chk("rd",        32'(out_rd), 32'(e.rd));
        chk("rs1",       32'(out_rs1), 32'(e.rs1));
        chk("rs2",       32'(out_rs2), 32'(e.rs2));
        chk("imm",       out_imm, e.imm);
        chk("alu_op",    32'(out_alu_op), 32'(e.alu));
        chk("alu1_pc",   32'(out_alu1_pc), 32'(e.a1));
        chk("alu2_imm",  32'(out_alu2_imm), 32'(e.a2));
        chk("jump_type", 32'(out_jump_type), 32'(e.jt));
        chk("rf_src",    32'(out_regfile_src), 32'(e.src));
        chk("mem_op",    32'(out_mem_op), 32'(e.mop));
        chk("mem_rd",    32'(out_mem_read_type), 32'(e.rt));
        chk("mem_mask",  32'(out_mem_write_mask), 32'(e.mask));
        chk("illegal",   32'(out_illegal), 32'(e.ill));
        chk("nom_illegal", 32'(n_illegal), 32'(e.ill | e.illn));
        chk("nom_alu_op",  32'(n_alu_op), (e.ill | e.illn) ? 32'd0 : 32'(e.alu));
    endtask

    task automatic chk_zero();
        chk("rst_pc",   out_pc, 32'd0);
        chk("rst_regs", 32'({out_rd, out_rs1, out_rs2}), 32'd0);
        chk("rst_imm",  out_imm, 32'd0);
        chk("rst_ctrl", 32'({out_alu_op, out_alu1_pc, out_alu2_imm, out_jump_type,
                             out_regfile_src, out_mem_op, out_mem_read_type,
                             out_mem_write_mask, out_illegal}), 32'd0);
    endtask

    // Inputs are set at the falling edge; check at +1, then advance the model.
    task automatic cycle();
        bit xo, acc;
        #1;
        chk("in_ready",      32'(in_ready), 32'(!m_valid || out_ready));
        chk("nom_in_ready",  32'(n_in_ready), 32'(!m_valid || out_ready));
        chk("out_valid",     32'(out_valid), 32'(m_valid));
        chk("nom_out_valid", 32'(n_out_valid), 32'(m_valid));
        if (m_valid && q.size() > 0) chk_bundle(q[0]);
        xo  = m_valid && out_ready && !flush && !rst;
        acc = in_valid && (!m_valid || out_ready) && !flush && !rst;
        if (rst || flush) begin
            q.delete();
            m_valid = 1'b0;
        end else begin
            if (xo) void'(q.pop_front());
            if (acc) q.push_back(nxt);
            m_valid = acc || (m_valid && !xo);
        end
        @(negedge clk);
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        nxt      = e;
        cycle();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        cycle();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_instr = 32'd0; in_pc = 32'd0;
        nxt = mk_ill(32'd0);
        @(negedge clk);
        cycle();
        cycle();
        #1 chk_zero();
        rst = 1'b0;

        // Back-to-back stream covering every format and the illegal cases.
        offer(32'hFFB10093, 32'h1000, mk(32'h1000, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFB, A_ADD, 0, 1, J_NONE, S_ALU, M_NONE, R_NONE, 4'h0, 0, 0));
        offer(32'h022081B3, 32'h1004, mk(32'h1004, 5'd3, 5'd1, 5'd2, 32'd0, A_MUL, 0, 0, J_NONE, S_ALU, M_NONE, R_NONE, 4'h0, 0, 1));
        offer(32'h00002063, 32'h1008, mk_ill(32'h1008));
        offer(32'h00000013, 32'h100C, mk(32'h100C, 5'd0, 5'd0, 5'd0, 32'd0, A_ADD, 0, 1, J_NONE, S_ALU, M_NONE, R_NONE, 4'h0, 0, 0));
        offer(32'h00512423, 32'h1010, mk(32'h1010, 5'd0, 5'd2, 5'd5, 32'd8, A_ADD, 0, 1, J_NONE, S_NONE, M_WR, R_NONE, 4'hF, 0, 0));
        offer(32'hFFF1C383, 32'h1014, mk(32'h1014, 5'd7, 5'd3, 5'd0, 32'hFFFFFFFF, A_ADD, 0, 1, J_NONE, S_MEM, M_RD, R_LBU, 4'h0, 0, 0));
        offer(32'hFE209EE3, 32'h1018, mk(32'h1018, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, A_XOR, 0, 0, J_IF1, S_NONE, M_NONE, R_NONE, 4'h0, 0, 0));
        offer(32'h001000EF, 32'h101C, mk(32'h101C, 5'd1, 5'd0, 5'd0, 32'h800, A_ADD, 1, 1, J_JAL, S_PC4, M_NONE, R_NONE, 4'h0, 0, 0));
        offer(32'h123452B7, 32'h1020, mk(32'h1020, 5'd5, 5'd0, 5'd0, 32'h12345000, A_NONE, 0, 0, J_NONE, S_IMM, M_NONE, R_NONE, 4'h0, 0, 0));
        offer(32'h00001317, 32'h1024, mk(32'h1024, 5'd6, 5'd0, 5'd0, 32'h1000, A_ADD, 1, 1, J_NONE, S_ALU, M_NONE, R_NONE, 4'h0, 0, 0));
        offer(32'h40628233, 32'h1028, mk(32'h1028, 5'd4, 5'd5, 5'd6, 32'd0, A_SUB, 0, 0, J_NONE, S_ALU, M_NONE, R_NONE, 4'h0, 0, 0));
        offer(32'h40001033, 32'h102C, mk_ill(32'h102C));
        offer(32'h4030D093, 32'h1030, mk(32'h1030, 5'd1, 5'd1, 5'd0, 32'h403, A_SRA, 0, 1, J_NONE, S_ALU, M_NONE, R_NONE, 4'h0, 0, 0));
        offer(32'h00000010, 32'h1034, mk_ill(32'h1034));
        offer(32'h02A4D433, 32'h1038, mk(32'h1038, 5'd8, 5'd9, 5'd10, 32'd0, A_DIVU, 0, 0, J_NONE, S_ALU, M_NONE, R_NONE, 4'h0, 0, 1));
        offer(32'h00001067, 32'h103C, mk_ill(32'h103C));
        offer(32'h00003003, 32'h1040, mk_ill(32'h1040));
        offer(32'h004280E7, 32'h1044, mk(32'h1044, 5'd1, 5'd5, 5'd0, 32'd4, A_ADD, 0, 1, J_JALR, S_PC4, M_NONE, R_NONE, 4'h0, 0, 0));
        offer(32'h0041D863, 32'h1048, mk(32'h1048, 5'd0, 5'd3, 5'd4, 32'd16, A_SLT, 0, 0, J_IF0, S_NONE, M_NONE, R_NONE, 4'h0, 0, 0));
        idle();
        idle();

        // Backpressure: first bundle held, second offer waits, then follows.
        out_ready = 1'b0;
        offer(32'hFFB10093, 32'h2000, mk(32'h2000, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFB, A_ADD, 0, 1, J_NONE, S_ALU, M_NONE, R_NONE, 4'h0, 0, 0));
        for (int i = 0; i < 3; i++)
            offer(32'h123452B7, 32'h2004, mk(32'h2004, 5'd5, 5'd0, 5'd0, 32'h12345000, A_NONE, 0, 0, J_NONE, S_IMM, M_NONE, R_NONE, 4'h0, 0, 0));
        out_ready = 1'b1;
        cycle();
        idle();
        idle();

        // Flush with a held bundle and a pending offer.
        out_ready = 1'b0;
        offer(32'h00000013, 32'h3000, mk(32'h3000, 5'd0, 5'd0, 5'd0, 32'd0, A_ADD, 0, 1, J_NONE, S_ALU, M_NONE, R_NONE, 4'h0, 0, 0));
        flush = 1'b1;
        offer(32'h00001317, 32'h3004, mk(32'h3004, 5'd6, 5'd0, 5'd0, 32'h1000, A_ADD, 1, 1, J_NONE, S_ALU, M_NONE, R_NONE, 4'h0, 0, 0));
        flush = 1'b0;
        out_ready = 1'b1;
        idle();
        idle();

        // Reset mid-stream, then the first instruction afterwards.
        out_ready = 1'b0;
        offer(32'h40628233, 32'h4000, mk(32'h4000, 5'd4, 5'd5, 5'd6, 32'd0, A_SUB, 0, 0, J_NONE, S_ALU, M_NONE, R_NONE, 4'h0, 0, 0));
        rst = 1'b1;
        offer(32'hFFF1C383, 32'h4004, mk_ill(32'h4004));
        rst = 1'b0;
        in_valid = 1'b0;
        #1 chk_zero();
        out_ready = 1'b1;
        offer(32'hFFB10093, 32'h5000, mk(32'h5000, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFB, A_ADD, 0, 1, J_NONE, S_ALU, M_NONE, R_NONE, 4'h0, 0, 0));
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
